// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-slot and execute-slot handshake bundle for id_ex_stage
interface id_ex_stage_if #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_ADDR_W = 3,
    parameter int OPCODE_W   = 4
);
    logic                  id_valid;
    logic                  id_ready;
    logic [OPCODE_W-1:0]   id_opcode;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic [DATA_WIDTH-1:0] id_rs_data;
    logic [DATA_WIDTH-1:0] id_rt_data;
    logic [DATA_WIDTH-1:0] id_imm;
    logic                  id_alu_src;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;

    logic                  ex_ready;
    logic                  ex_valid;
    logic [OPCODE_W-1:0]   ex_opcode;
    logic [DATA_WIDTH-1:0] ex_op_a;
    logic [DATA_WIDTH-1:0] ex_op_b;
    logic [DATA_WIDTH-1:0] ex_store_data;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;

    // master: the decode/execute environment around the stage
    modport master (
        output id_valid, id_opcode, id_rs_addr, id_rt_addr, id_rd_addr,
               id_rs_data, id_rt_data, id_imm, id_alu_src, id_reg_write,
               id_mem_read, id_mem_write, ex_ready,
        input  id_ready, ex_valid, ex_opcode, ex_op_a, ex_op_b, ex_store_data,
               ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, id_opcode, id_rs_addr, id_rt_addr, id_rd_addr,
               id_rs_data, id_rt_data, id_imm, id_alu_src, id_reg_write,
               id_mem_read, id_mem_write, ex_ready,
        output id_ready, ex_valid, ex_opcode, ex_op_a, ex_op_b, ex_store_data,
               ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode->execute pipeline register with load-use bubble; optional FORWARDING_EN
module id_ex_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_ADDR_W = 3,
    parameter int OPCODE_W   = 4,
    parameter int PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    id_ex_stage_if.slave          bus,
    input  logic                  flush,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [PERF_W-1:0]     stall_cnt
);
    typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;

    state_t                state;
    logic                  advance;
    logic                  rt_hit;
    logic                  hazard;
    logic [DATA_WIDTH-1:0] rs_val;
    logic [DATA_WIDTH-1:0] rt_val;

    assign bus.ex_valid = (state == FULL);
    assign advance      = !bus.ex_valid || bus.ex_ready;

    // rt only matters when it is actually read: as ALU operand B or as store data
    assign rt_hit = (bus.ex_rd_addr == bus.id_rt_addr) &&
                    (!bus.id_alu_src || bus.id_mem_write);
    assign hazard = bus.ex_valid && bus.ex_mem_read && bus.ex_reg_write &&
                    (bus.ex_rd_addr != '0) &&
                    ((bus.ex_rd_addr == bus.id_rs_addr) || rt_hit);

    assign bus.id_ready = advance && !hazard && !reset;

`ifdef FORWARDING_EN
    assign rs_val = (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == bus.id_rs_addr))
                    ? wb_data : bus.id_rs_data;
    assign rt_val = (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == bus.id_rt_addr))
                    ? wb_data : bus.id_rt_data;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_reg_write, wb_rd_addr, wb_data};
    assign rs_val    = bus.id_rs_data;
    assign rt_val    = bus.id_rt_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= EMPTY;
            bus.ex_opcode     <= '0;
            bus.ex_op_a       <= '0;
            bus.ex_op_b       <= '0;
            bus.ex_store_data <= '0;
            bus.ex_rd_addr    <= '0;
            bus.ex_reg_write  <= 1'b0;
            bus.ex_mem_read   <= 1'b0;
            bus.ex_mem_write  <= 1'b0;
            stall_cnt         <= '0;
        end else if (flush) begin
            state            <= EMPTY;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_mem_write <= 1'b0;
        end else if (advance) begin
            if (bus.id_valid && !hazard) begin
                state             <= FULL;
                bus.ex_opcode     <= bus.id_opcode;
                bus.ex_op_a       <= rs_val;
                bus.ex_op_b       <= bus.id_alu_src ? bus.id_imm : rt_val;
                bus.ex_store_data <= rt_val;
                bus.ex_rd_addr    <= bus.id_rd_addr;
                bus.ex_reg_write  <= bus.id_reg_write;
                bus.ex_mem_read   <= bus.id_mem_read;
                bus.ex_mem_write  <= bus.id_mem_write;
            end else begin
                // bubble or idle slot: no control may leak into execute
                state            <= hazard ? BUBBLE : EMPTY;
                bus.ex_reg_write <= 1'b0;
                bus.ex_mem_read  <= 1'b0;
                bus.ex_mem_write <= 1'b0;
                if (hazard && (stall_cnt != '1))
                    stall_cnt <= stall_cnt + PERF_W'(1);
            end
        end
    end
endmodule
